mult_sequencer: RTL

- Initiator side of the multiplier's start/done handshake.
- Accepts 8x8 operand pairs on a valid/ready input stream and drives operands plus a single-cycle start pulse into the 8x8 shift-add multiplier.
- Waits for done, captures the 16-bit product and presents it on a valid/ready output stream.
- Detects a multiplier error state or a timeout, retries a bounded number of times, then reports failure.

---
 rtl/mult_sequencer_if.sv | 44 ++++
 rtl/mult_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: operand input stream, multiplier start/done link and
// result output stream seen by the multiplier sequencer.
// master = the sequencer, slave = its environment (source, multiplier, sink).
interface mult_sequencer_if;
  // operand stream
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_dataa;
  logic [7:0]  in_datab;
  // multiplier link
  logic [7:0]  mult_dataa;
  logic [7:0]  mult_datab;
  logic        mult_start;
  logic        mult_done;
  logic [2:0]  mult_state;
  logic [15:0] mult_product;
  // result stream
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        out_err;
  // status
  logic        busy;

  modport master (
    input  in_valid, in_dataa, in_datab,
    input  mult_done, mult_state, mult_product,
    input  out_ready,
    output in_ready,
    output mult_dataa, mult_datab, mult_start,
    output out_valid, out_product, out_err,
    output busy
  );

  modport slave (
    output in_valid, in_dataa, in_datab,
    output mult_done, mult_state, mult_product,
    output out_ready,
    input  in_ready,
    input  mult_dataa, mult_datab, mult_start,
    input  out_valid, out_product, out_err,
    input  busy
  );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer: initiator for the 8x8 shift-add multiplier. Takes an operand
// pair, fires a one-cycle start, waits for done, and returns the product on a
// valid/ready stream. Error state (3'b101) or a missing done triggers a bounded
// number of restarts before the result is flagged with out_err.
// Optional build macro MULT_SEQ_STATS_EN adds saturating result counters
// stat_ops / stat_errs.
module mult_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 1
) (
  input  logic                clk,
  input  logic                reset_a,
  mult_sequencer_if.master    bus
`ifdef MULT_SEQ_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_errs
`else
`endif
);

  // Timer only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [2:0]         MULT_ERR_STATE = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_in_ready;
  logic [7:0]          r_mult_dataa;
  logic [7:0]          r_mult_datab;
  logic                r_mult_start;
  logic                r_out_valid;
  logic [15:0]         r_out_product;
  logic                r_out_err;
  logic                r_busy;

  logic                w_fault;
  logic                w_can_retry;

  // Attempt has failed: multiplier reports error or done never arrived in time.
  assign w_fault     = (bus.mult_state == MULT_ERR_STATE) || (r_timer == TIMER_LAST);
  assign w_can_retry = (r_retry < RETRY_LIMIT);

  // Sequencer FSM with registered handshake and multiplier-side outputs.
  always_ff @(posedge clk) begin
    if (!reset_a) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_retry       <= '0;
      r_in_ready    <= 1'b1;
      r_mult_dataa  <= '0;
      r_mult_datab  <= '0;
      r_mult_start  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_out_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // start is a strict single-cycle pulse; only START-entry sets it
      r_mult_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_mult_dataa <= bus.in_dataa;
            r_mult_datab <= bus.in_datab;
            r_retry      <= '0;
            r_mult_start <= 1'b1;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end

        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_timer <= r_timer + TIMER_W'(1);
          if (bus.mult_done) begin
            // done wins over a coincident error/timeout
            r_out_product <= bus.mult_product;
            r_out_err     <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= S_OUT;
          end else if (w_fault) begin
            if (w_can_retry) begin
              // restart from the error state re-enters the LSB step
              r_retry      <= r_retry + RETRY_W'(1);
              r_mult_start <= 1'b1;
              r_state      <= S_START;
            end else begin
              r_out_product <= '0;
              r_out_err     <= 1'b1;
              r_out_valid   <= 1'b1;
              r_state       <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.mult_dataa  = r_mult_dataa;
  assign bus.mult_datab  = r_mult_datab;
  assign bus.mult_start  = r_mult_start;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_product = r_out_product;
  assign bus.out_err     = r_out_err;
  assign bus.busy        = r_busy;

`ifdef MULT_SEQ_STATS_EN
  logic [15:0] r_stat_ops;
  logic [15:0] r_stat_errs;

  // Saturating counts of delivered results and of failed results.
  always_ff @(posedge clk) begin
    if (!reset_a) begin
      r_stat_ops  <= '0;
      r_stat_errs <= '0;
    end else if (r_out_valid && bus.out_ready) begin
      if (r_stat_ops != 16'hFFFF) begin
        r_stat_ops <= r_stat_ops + 16'd1;
      end
      if (r_out_err && (r_stat_errs != 16'hFFFF)) begin
        r_stat_errs <= r_stat_errs + 16'd1;
      end
    end
  end

  assign stat_ops  = r_stat_ops;
  assign stat_errs = r_stat_errs;
`else
  // statistics counters are not built in this configuration
`endif

endmodule
